// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory command port between N_PORTS clients. Each grant is
//   held for up to MAX_HOLD accepted beats. A single command register sits
//   between the clients and the memory side. Read returns are steered back
//   to their issuing port through an in-order tag FIFO.
//
//   Ports
//     afi_phy_clk, afi_phy_rst_n        clock, async active-low reset
//     port_req/we/addr/wdata            packed per-port command inputs
//     port_ready                        per-port command accept (one-hot or 0)
//     port_rdata, port_rdata_valid      broadcast read data, one-hot qualifier
//     local_address/wdata/write_req/read_req, local_ready
//                                       memory-side command handshake
//     local_rdata, local_rdata_valid    memory read return (in issue order)
//     err_orphan                        sticky: a return arrived with no tag
//     tag_full                          outstanding-read tag FIFO is full
module mem_port_arbiter #(
   parameter int N_PORTS    = 3,
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MAX_HOLD   = 16,
   parameter int TAG_DEPTH  = 8,
   parameter int FIXED_PRIO = 0
) (
   input  logic                       afi_phy_clk,
   input  logic                       afi_phy_rst_n,
   input  logic [N_PORTS-1:0]         port_req,
   input  logic [N_PORTS-1:0]         port_we,
   input  logic [N_PORTS*ADDR_W-1:0]  port_addr,
   input  logic [N_PORTS*DATA_W-1:0]  port_wdata,
   output logic [N_PORTS-1:0]         port_ready,
   output logic [DATA_W-1:0]          port_rdata,
   output logic [N_PORTS-1:0]         port_rdata_valid,
   output logic [ADDR_W-1:0]          local_address,
   output logic [DATA_W-1:0]          local_wdata,
   output logic                       local_write_req,
   output logic                       local_read_req,
   input  logic                       local_ready,
   input  logic [DATA_W-1:0]          local_rdata,
   input  logic                       local_rdata_valid,
   output logic                       err_orphan,
   output logic                       tag_full
);

   localparam int GW = $clog2(N_PORTS);
   localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
   localparam int CW = $clog2(TAG_DEPTH + 1);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t          state, state_nxt;
   logic [GW-1:0]   grant, grant_nxt;
   logic [GW-1:0]   last_grant, last_grant_nxt;
   logic [GW-1:0]   winner, cand;
   logic [7:0]      beat_cnt, beat_cnt_nxt;
   int unsigned     rr_idx;
   logic            accept, cmd_free, cmd_valid, cmd_we;
   logic            push, pop;
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   tag_cnt;
   logic [GW-1:0]   tag_mem [TAG_DEPTH];

   // Winner search. Loops run from the far end so the last assignment is the
   // first match in search order.
   always_comb begin
      winner = '0;
      cand   = '0;
      rr_idx = 0;
      if (FIXED_PRIO != 0) begin
         for (int unsigned k = N_PORTS; k > 0; k--) begin
            cand = GW'(k - 1);
            if (port_req[cand]) winner = cand;
         end
      end else begin
         for (int unsigned k = N_PORTS; k > 0; k--) begin
            rr_idx = 32'(last_grant) + k;
            if (rr_idx >= 32'(N_PORTS)) rr_idx = rr_idx - 32'(N_PORTS);
            cand = GW'(rr_idx);
            if (port_req[cand]) winner = cand;
         end
      end
   end

   assign cmd_free = !cmd_valid || local_ready;

   // Next-state and accept logic. The cycle that leaves HOLD never accepts.
   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant;
      last_grant_nxt = last_grant;
      beat_cnt_nxt   = beat_cnt;
      port_ready     = '0;
      accept         = 1'b0;
      case (state)
         IDLE: begin
            if (|port_req) begin
               state_nxt    = HOLD;
               grant_nxt    = winner;
               beat_cnt_nxt = '0;
            end
         end
         HOLD: begin
            if (!(port_req[grant] && (beat_cnt < 8'(MAX_HOLD)))) begin
               state_nxt      = IDLE;
               last_grant_nxt = grant;
            end else if (cmd_free && (port_we[grant] || !tag_full)) begin
               accept            = 1'b1;
               port_ready[grant] = 1'b1;
               beat_cnt_nxt      = beat_cnt + 8'd1;
            end
         end
      endcase
   end

   always_ff @(posedge afi_phy_clk or negedge afi_phy_rst_n) begin
      if (!afi_phy_rst_n) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= GW'(N_PORTS - 1);
         beat_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         last_grant <= last_grant_nxt;
         beat_cnt   <= beat_cnt_nxt;
      end
   end

   // Command register: loads on accept, drains when the memory takes it.
   always_ff @(posedge afi_phy_clk or negedge afi_phy_rst_n) begin
      if (!afi_phy_rst_n) begin
         cmd_valid     <= 1'b0;
         cmd_we        <= 1'b0;
         local_address <= '0;
         local_wdata   <= '0;
      end else if (accept) begin
         cmd_valid     <= 1'b1;
         cmd_we        <= port_we[grant];
         local_address <= port_addr[32'(grant) * ADDR_W +: ADDR_W];
         local_wdata   <= port_wdata[32'(grant) * DATA_W +: DATA_W];
      end else if (local_ready) begin
         cmd_valid     <= 1'b0;
      end
   end

   assign local_write_req = cmd_valid && cmd_we;
   assign local_read_req  = cmd_valid && !cmd_we;

   // Tag FIFO of issuing port indices for outstanding reads.
   assign push     = accept && !port_we[grant];
   assign pop      = local_rdata_valid && (tag_cnt != '0);
   assign tag_full = (tag_cnt == CW'(TAG_DEPTH));

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(TAG_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge afi_phy_clk or negedge afi_phy_rst_n) begin
      if (!afi_phy_rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         tag_cnt    <= '0;
         err_orphan <= 1'b0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   tag_cnt <= tag_cnt + CW'(1);
            2'b01:   tag_cnt <= tag_cnt - CW'(1);
            default: tag_cnt <= tag_cnt;
         endcase
         if (local_rdata_valid && (tag_cnt == '0)) err_orphan <= 1'b1;
      end
   end

   always_ff @(posedge afi_phy_clk) begin
      if (push) tag_mem[wr_ptr] <= grant;
   end

   assign port_rdata       = local_rdata;
   assign port_rdata_valid = pop ? (N_PORTS'(1) << tag_mem[rd_ptr]) : '0;

endmodule
